// File: rtl/minterm_lut_reg.sv
// minterm_lut_reg
// Registered truth-table evaluator. Each channel holds its own serially
// loaded 2^N_IN-entry truth table. In IDLE, every channel's registered
// output follows the table entry selected by in_vec. On request, a built-in
// sweep engine steps through every minterm and streams the minterm index
// together with the registered outputs.
//
// Ports
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset; clears the tables as well
//   ld_en        serial load strobe; one table bit per cycle
//   ld_ch        channel whose table receives the bit
//   ld_bit       bit written at the shared load pointer
//   ld_rst       returns the load pointer to 0; overrides ld_en
//   in_vec       live input vector; the MSB is variable A
//   sweep_start  requests an exhaustive minterm sweep (accepted in IDLE only)
//   out_q        registered outputs; bit c belongs to channel c
//   sweep_m      minterm index that matches out_q during a sweep
//   sweep_valid  out_q and sweep_m hold a sweep sample
//   sweep_done   one-cycle pulse after the last sweep sample
//   busy         a sweep is in progress (state other than IDLE)
//   ld_wrap      one-cycle pulse after the write at pointer TT-1
module minterm_lut_reg #(
  parameter int N_IN = 4,
  parameter int N_CH = 2,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            ld_en,
  input  logic [CH_W-1:0] ld_ch,
  input  logic            ld_bit,
  input  logic            ld_rst,
  input  logic [N_IN-1:0] in_vec,
  input  logic            sweep_start,
  output logic [N_CH-1:0] out_q,
  output logic [N_IN-1:0] sweep_m,
  output logic            sweep_valid,
  output logic            sweep_done,
  output logic            busy,
  output logic            ld_wrap
);

  localparam int TT = 1 << N_IN;

  // The sweep counter has one extra bit, so the compare against the last
  // minterm cannot alias.
  localparam logic [N_IN:0]   M_LAST   = (N_IN + 1)'(TT - 1);
  localparam logic [N_IN-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [TT-1:0]   tt [N_CH];
  logic [N_IN-1:0] ld_ptr;
  logic [N_IN:0]   m;

  assign busy = (state != IDLE);

  // DONE lasts two cycles. In the first cycle, sweep_done is raised.
  // In the second cycle, sweep_done is cleared and the FSM returns to IDLE.
  // Because of this, the sweep_done register also marks which of the two
  // DONE cycles is current.
  // Loads and ld_rst take effect only in IDLE. While busy they are ignored.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int c = 0; c < N_CH; c++) begin
        tt[c] <= '0;
      end
      ld_ptr      <= '0;
      state       <= IDLE;
      m           <= '0;
      out_q       <= '0;
      sweep_m     <= '0;
      sweep_valid <= 1'b0;
      sweep_done  <= 1'b0;
      ld_wrap     <= 1'b0;
    end else begin
      ld_wrap <= 1'b0;
      case (state)
        IDLE: begin
          sweep_valid <= 1'b0;
          sweep_done  <= 1'b0;
          for (int c = 0; c < N_CH; c++) begin
            out_q[c] <= tt[c][in_vec];
          end
          if (ld_rst) begin
            ld_ptr <= '0;
          end else if (ld_en) begin
            for (int c = 0; c < N_CH; c++) begin
              if (c == int'(ld_ch)) begin
                tt[c][ld_ptr] <= ld_bit;
              end
            end
            ld_ptr  <= ld_ptr + N_IN'(1);
            ld_wrap <= (ld_ptr == PTR_LAST);
          end
          if (sweep_start) begin
            state <= SWEEP;
            m     <= '0;
          end
        end
        SWEEP: begin
          for (int c = 0; c < N_CH; c++) begin
            out_q[c] <= tt[c][m[N_IN-1:0]];
          end
          sweep_m     <= m[N_IN-1:0];
          sweep_valid <= 1'b1;
          m           <= m + (N_IN + 1)'(1);
          if (m == M_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          sweep_valid <= 1'b0;
          if (!sweep_done) begin
            sweep_done <= 1'b1;
          end else begin
            sweep_done <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_lut_reg.sv
// tb_minterm_lut_reg
// Self-checking bench for minterm_lut_reg with N_IN=4 and N_CH=2. The bench
// keeps a reference copy of both truth tables and of the load pointer. When
// stimulus is applied, expected results are pushed to a scoreboard queue.
// They are popped when the DUT presents a result.
module tb_minterm_lut_reg;

  localparam int N_IN = 4;
  localparam int N_CH = 2;
  localparam int TT   = 16;

  logic            clk = 1'b0;
  logic            clr_n = 1'b0;
  logic            ld_en = 1'b0;
  logic [0:0]      ld_ch = 1'b0;
  logic            ld_bit = 1'b0;
  logic            ld_rst = 1'b0;
  logic [N_IN-1:0] in_vec = '0;
  logic            sweep_start = 1'b0;
  logic [N_CH-1:0] out_q;
  logic [N_IN-1:0] sweep_m;
  logic            sweep_valid;
  logic            sweep_done;
  logic            busy;
  logic            ld_wrap;

  typedef struct packed {
    logic [3:0] m;
    logic [1:0] q;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mtt [2];
  int          mptr = 0;

  minterm_lut_reg #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .ld_en(ld_en),
    .ld_ch(ld_ch),
    .ld_bit(ld_bit),
    .ld_rst(ld_rst),
    .in_vec(in_vec),
    .sweep_start(sweep_start),
    .out_q(out_q),
    .sweep_m(sweep_m),
    .sweep_valid(sweep_valid),
    .sweep_done(sweep_done),
    .busy(busy),
    .ld_wrap(ld_wrap)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_q(input logic [3:0] v);
    return {mtt[1][v], mtt[0][v]};
  endfunction

  task automatic model_clear;
    mtt[0] = '0;
    mtt[1] = '0;
    mptr   = 0;
  endtask

  // One serial load beat; checks ld_wrap against the reference pointer.
  task automatic load_beat(input logic ch, input logic b);
    logic exp_wrap;
    ld_en  = 1'b1;
    ld_ch  = ch;
    ld_bit = b;
    tick;
    exp_wrap = (mptr == TT - 1);
    mtt[ch][mptr] = b;
    mptr = (mptr + 1) % TT;
    ld_en = 1'b0;
    checkOutput("ld_wrap", {31'd0, ld_wrap}, {31'd0, exp_wrap});
  endtask

  // IDLE evaluation: drive in_vec, queue the reference result, and compare
  // it with out_q one edge later.
  task automatic applyStimulus(input logic [3:0] v);
    exp_t e;
    in_vec = v;
    sb.push_back({v, model_q(v)});
    tick;
    e = sb.pop_front();
    checkOutput("idle_q", {30'd0, out_q}, {30'd0, e.q});
  endtask

  // Full sweep. If disturb is set, loads, ld_rst and extra starts are
  // driven while the engine is busy.
  task automatic run_sweep(input bit disturb);
    exp_t e;
    for (int mm = 0; mm < TT; mm++) begin
      sb.push_back({4'(mm), model_q(4'(mm))});
    end
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_valid", {31'd0, sweep_valid}, 32'd0);
    for (int i = 1; i <= TT + 3; i++) begin
      tick;
      if (sweep_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("sweep_m", {28'd0, sweep_m}, {28'd0, e.m});
          checkOutput("sweep_q", {30'd0, out_q}, {30'd0, e.q});
        end
      end
      checkOutput("sweep_valid", {31'd0, sweep_valid}, {31'd0, (i <= TT)});
      if (i == TT + 1) begin
        checkOutput("done_pulse", {31'd0, sweep_done}, 32'd1);
      end else begin
        checkOutput("done_low", {31'd0, sweep_done}, 32'd0);
      end
      checkOutput("busy", {31'd0, busy}, {31'd0, (i <= TT + 1)});
      ld_en       = 1'b0;
      ld_rst      = 1'b0;
      sweep_start = 1'b0;
      if (disturb) begin
        if ((i >= 3 && i <= 6) || i == TT) begin
          ld_en  = 1'b1;
          ld_ch  = 1'b1;
          ld_bit = 1'b1;
        end
        if (i == 7) ld_rst = 1'b1;
        if (i == 9 || i == TT + 1) sweep_start = 1'b1;
      end
    end
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] pat0;
    bit          found;
    model_clear();

    // Reset with active requests: everything must stay 0.
    clr_n       = 1'b0;
    sweep_start = 1'b1;
    ld_en       = 1'b1;
    ld_bit      = 1'b1;
    repeat (3) tick;
    checkOutput("rst_out_q", {30'd0, out_q}, 32'd0);
    checkOutput("rst_valid", {31'd0, sweep_valid}, 32'd0);
    checkOutput("rst_done", {31'd0, sweep_done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wrap", {31'd0, ld_wrap}, 32'd0);
    checkOutput("rst_sweep_m", {28'd0, sweep_m}, 32'd0);
    sweep_start = 1'b0;
    ld_en       = 1'b0;
    ld_bit      = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    checkOutput("release_busy", {31'd0, busy}, 32'd0);
    checkOutput("release_q", {30'd0, out_q}, 32'd0);
    tick;
    checkOutput("first_edge_busy", {31'd0, busy}, 32'd0);

    // Load ch0 with FF80 (bit m first) and ch1 with 0; wrap after beats 16 and 32.
    pat0 = 16'hFF80;
    for (int i = 0; i < TT; i++) load_beat(1'b0, pat0[i]);
    for (int i = 0; i < TT; i++) load_beat(1'b1, 1'b0);

    applyStimulus(4'b0111);
    checkOutput("tp_0111", {30'd0, out_q}, 32'd1);
    applyStimulus(4'b0110);
    checkOutput("tp_0110", {30'd0, out_q}, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(4'($urandom_range(0, 15)));

    // Sweep with disturbances, then confirm nothing changed.
    run_sweep(1'b1);
    for (int v = 0; v < TT; v++) applyStimulus(4'(v));
    // The pointer must still be 0: rewriting ch0 should wrap on beat 16.
    for (int i = 0; i < TT; i++) load_beat(1'b0, mtt[0][i]);

    // ld_rst wins over ld_en at pointer 5; the next beat writes entry 0.
    ld_rst = 1'b1;
    tick;
    ld_rst = 1'b0;
    mptr = 0;
    for (int i = 0; i < 5; i++) load_beat(1'b1, 1'b0);
    ld_rst = 1'b1;
    ld_en  = 1'b1;
    ld_ch  = 1'b1;
    ld_bit = 1'b1;
    tick;
    ld_rst = 1'b0;
    ld_en  = 1'b0;
    mptr   = 0;
    checkOutput("rst_en_wrap", {31'd0, ld_wrap}, 32'd0);
    load_beat(1'b1, 1'b1);
    applyStimulus(4'd0);
    checkOutput("entry0_written", {30'd0, out_q}, 32'd2);
    applyStimulus(4'd5);
    checkOutput("entry5_clean", {30'd0, out_q}, 32'd0);
    for (int i = 1; i < TT; i++) load_beat(1'b1, mtt[1][i]);

    // Plain sweep of the current tables.
    run_sweep(1'b0);

    // Reset at sample m=9, then sweep the cleared tables.
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick;
      if (sweep_valid && sweep_m == 4'd9) found = 1'b1;
    end
    checkOutput("reach_m9", {31'd0, found}, 32'd1);
    clr_n = 1'b0;
    #1;
    checkOutput("mid_rst_q", {30'd0, out_q}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, sweep_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_m", {28'd0, sweep_m}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    model_clear();
    sb.delete();
    run_sweep(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minterm_lut_reg.md
# minterm_lut_reg

Parametrised, registered truth-table evaluator: holds one loadable 2^N_IN-entry truth table per channel and drives each channel's registered output from the current input vector. A built-in sweep engine walks every minterm m = 0..2^N_IN-1 on its own and streams m with the registered outputs. It replaces the fixed, hand-simplified single-function-plus-D-flip-flop blocks in the logic-simplification exercises. One table reload now retargets any N_IN-variable function, with self-checking exhaustive sweeps.

## Interface
- N_IN, 4, number of input variables; table depth TT = 2^N_IN, N_IN ≥ 1
- N_CH, 2, number of independent channels (functions), N_CH ≥ 1
- CH_W (localparam), max(1, clog2(N_CH)), channel-select width
- clk  in  1  rising-edge clock; single clock domain
- clr_n  in  1  asynchronous, active-low reset
- ld_en  in  1  serial table-load strobe, one bit per cycle
- ld_ch  in  CH_W  channel whose table is written
- ld_bit  in  1  truth-table bit written at current load pointer
- ld_rst  in  1  return load pointer to 0
- in_vec  in  N_IN  live input vector, bit N_IN-1 = variable A (MSB)
- sweep_start  in  1  request an exhaustive minterm sweep
- out_q  out  N_CH  registered function outputs, bit c = channel c
- sweep_m  out  N_IN  minterm index belonging to current out_q during sweep
- sweep_valid  out  1  out_q/sweep_m carry a sweep sample
- sweep_done  out  1  one-cycle pulse after last sweep sample
- busy  out  1  sweep in progress
- ld_wrap  out  1  one-cycle pulse when load pointer wraps TT-1 → 0

## Operation
- Storage: N_CH × TT bit array tt[c][m]; output for minterm m is tt[c][m].
- Load: on ld_en in IDLE, tt[ld_ch][ld_ptr] ← ld_bit, ld_ptr ← ld_ptr+1 mod TT. The write at ld_ptr = TT-1 pulses ld_wrap next cycle.
- ld_ptr is shared by all channels. ld_ch may change per beat; the pointer does not reset on a channel change.
- ld_rst: ld_ptr ← 0. If it coincides with ld_en, ld_rst wins and nothing is written.
- ld_en/ld_rst while busy: ignored, with no write and no pointer change.
- FSM states:
  - IDLE: out_q ← tt[c][in_vec] for every c; sweep_valid = 0. sweep_start → SWEEP with counter m ← 0.
  - SWEEP: out_q ← tt[c][m], sweep_m ← m, sweep_valid ← 1, m ← m+1. At m = TT-1 → DONE.
  - DONE: sweep_valid ← 0, sweep_done ← 1 for one cycle, then → IDLE.
- busy = (state ≠ IDLE).
- sweep_start is ignored unless the state is IDLE, so a start asserted in DONE has no effect.
- in_vec is ignored during SWEEP and DONE.
- Counter m is N_IN+1 bits internally so the TT-1 compare cannot alias. sweep_m is its low N_IN bits.

## Timing
- Reset (clr_n low, asynchronous): all tt bits 0, ld_ptr 0, state IDLE, m 0. out_q, sweep_m, sweep_valid, sweep_done, busy and ld_wrap all 0.
- IDLE eval latency: in_vec at edge k → out_q valid after edge k (1 cycle, registered).
- Load-to-use: bit written at edge k is visible in out_q from edge k+1 (read-after-write is the new value).
- Sweep: sweep_start high at edge k → busy=1 after k.
  - Samples m = 0..TT-1 appear after edges k+1..k+TT with sweep_valid=1.
  - sweep_done=1 and busy=1 after edge k+TT+1.
  - busy=0 after edge k+TT+2.
  - Total: TT+2 cycles start-to-idle.
- ld_wrap: asserted for exactly the cycle after the wrapping write.
- clr_n asserted mid-sweep or mid-load: immediate return to reset values; tables lost. After release, the first edge behaves as IDLE.

## Test plan
- Reset: hold clr_n=0 with sweep_start=1 and ld_en=1 → all outputs 0. No output changes until the first edge after clr_n=1.
- Load ch0 with 16'hFF80 (bit m first, m=0..15) and ch1 with 16'h0000 → ld_wrap pulses after the 16th and 32nd beats. IDLE in_vec=4'b0111 → out_q=2'b01; in_vec=4'b0110 → out_q=2'b00, one cycle later each.
- Sweep after the above load → 16 consecutive sweep_valid cycles with sweep_m 0..15. out_q[0] is 0 for m<7 and 1 for m≥7; out_q[1] is 0 throughout. Then one sweep_done cycle, busy drops at TT+2.
- ld_en, ld_rst and a second sweep_start asserted during a sweep → table and ld_ptr unchanged, with no second sweep. A follow-up IDLE read matches the pre-sweep contents.
- ld_rst and ld_en together with ld_bit=1 at ld_ptr=5 → no write, ld_ptr=0. The next ld_en writes entry 0.
- clr_n pulsed low at sweep sample m=9 → outputs 0 immediately and table cleared. A new sweep yields out_q=0 for all 16 samples.
